result_arbiter: RTL
===================

RESULT_ARBITER -- requirements
Module: result_arbiter

Interface
REQ-001 SHALL have parameter N_ENG, default 8: number of engines served, range 2..32.
REQ-002 SHALL have parameter FB_W, default 640: frame width in pixels.
REQ-003 SHALL have parameter FB_H, default 480: frame height in pixels.
REQ-004 SHALL have port Engine_CLK, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port eRST, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have port service_req, input, N_ENG: bit i high means engine i holds a finished result.
REQ-007 SHALL have port req_ack, output, N_ENG: one-hot-or-zero grant; bit i lets engine i drive the shared result bus.
REQ-008 SHALL have port res_bus, input, 27: shared tri-state result bus {x[9:0], y[8:0], iter[7:0]}.
REQ-009 SHALL have port fb_ready, input, 1: frame buffer accepts a write this cycle.
REQ-010 SHALL have port fb_we, output, 1: frame buffer write strobe.
REQ-011 SHALL have port fb_addr, output, 19: pixel address.
REQ-012 SHALL have port fb_data, output, 8: iteration count.
REQ-013 SHALL have port frame_start, input, 1: synchronous clear of pixel counter and range_err.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse on the last pixel of a frame.
REQ-015 SHALL have port range_err, output, 1: sticky flag for an out-of-range coordinate.

Function
REQ-016 SHALL implement states IDLE, ACK, WRITE, RELEASE.
REQ-017 IDLE: if any service_req bit is high, SHALL select the first set bit searching from (last_grant+1) mod N_ENG upward with wrap, register it as grant, and go to ACK; otherwise SHALL stay in IDLE.
REQ-018 ACK: SHALL drive req_ack[grant]=1 for exactly one cycle, capture res_bus into x/y/iter registers at the end of that cycle, set last_grant=grant, and go to WRITE.
REQ-019 req_ack SHALL be registered, SHALL never have more than one bit set, and SHALL be all-zero outside ACK.
REQ-020 WRITE: SHALL hold fb_we=1 with stable fb_addr and fb_data until a cycle in which fb_ready=1, then go to RELEASE; fb_we SHALL be 0 in all other states.
REQ-021 fb_addr SHALL equal y*FB_W + x, computed at full width and truncated to 19 bits; fb_data SHALL equal the captured iter.
REQ-022 If the captured x>=FB_W or y>=FB_H, WRITE SHALL set range_err, keep fb_we=0, skip the pixel count, and go to RELEASE next cycle.
REQ-023 RELEASE: SHALL last exactly one cycle with req_ack all-zero, then go to IDLE; the minimum grant-to-grant spacing is therefore 4 cycles.
REQ-024 The pixel counter, 19 bits, SHALL increment on every completed fb_we&fb_ready cycle.
REQ-025 When the increment reaches FB_W*FB_H, the counter SHALL wrap to 0 and frame_done SHALL pulse in the following cycle.
REQ-026 frame_start SHALL clear the counter and range_err; if a write completes in the same cycle, the counter SHALL become 1 and range_err SHALL be cleared.
REQ-027 A service_req deasserting while its engine is not granted SHALL be ignored; service_req[grant] low during ACK SHALL still complete the capture.
REQ-028 With all N_ENG requests held high, grants SHALL rotate 0,1,...,N_ENG-1,0 with no engine starved.

Reset
REQ-029 eRST high SHALL immediately force state=IDLE, req_ack=0, fb_we=0, frame_done=0, range_err=0, pixel counter=0, last_grant=N_ENG-1 (so the first search starts at engine 0), and x/y/iter capture registers=0.
REQ-030 eRST asserted mid-transfer (ACK or WRITE) SHALL abandon the result with no fb_we pulse after reset releases; the engine's own reset covers recovery.

Verification
REQ-031 Single request, fb_ready tied 1: service_req=0x04, res_bus={x=5,y=2,iter=0x3A} -> req_ack=0x04 for 1 cycle, then fb_we 1 cycle with fb_addr=1285, fb_data=0x3A.
REQ-032 All requests high, N_ENG=8 -> grant order 0..7,0, spaced 4 cycles apart, never two bits of req_ack set.
REQ-033 fb_ready held 0 for 5 cycles in WRITE -> fb_we stays high with stable addr/data, no new req_ack, completes on the first fb_ready=1.
REQ-034 x=640,y=0 captured -> no fb_we, range_err=1 until frame_start, counter unchanged.
REQ-035 307200 valid writes after frame_start -> frame_done pulses once for one cycle, counter=0; a write in the same cycle as frame_start -> counter=1.
REQ-036 eRST pulse during WRITE -> all outputs reset asynchronously, and the next grant goes to the lowest pending engine.

Source files
------------

// File: rtl/result_arbiter.sv
// Result arbiter: round-robin collection of finished results from N_ENG engines over a
// shared result bus, written one pixel at a time into the frame buffer.
module result_arbiter #(
    parameter int unsigned N_ENG = 8,
    parameter int unsigned FB_W  = 640,
    parameter int unsigned FB_H  = 480
) (
    input  logic             Engine_CLK,
    input  logic             eRST,
    input  logic [N_ENG-1:0] service_req,
    output logic [N_ENG-1:0] req_ack,
    input  logic [26:0]      res_bus,
    input  logic             fb_ready,
    output logic             fb_we,
    output logic [18:0]      fb_addr,
    output logic [7:0]       fb_data,
    input  logic             frame_start,
    output logic             frame_done,
    output logic             range_err
);

    localparam int unsigned GrantW  = $clog2(N_ENG);
    localparam int unsigned FrameSz = FB_W * FB_H;

    typedef enum logic [1:0] {StIdle, StAck, StWrite, StRelease} state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic [GrantW-1:0]  r_grant;
    logic [GrantW-1:0]  r_last_grant;
    logic [N_ENG-1:0]   r_ack;
    logic [9:0]         r_x;
    logic [8:0]         r_y;
    logic [7:0]         r_iter;
    logic [18:0]        r_pix_cnt;
    logic               r_frame_done;
    logic               r_range_err;

    logic [GrantW-1:0]  w_pick;
    logic [GrantW:0]    w_sum;
    logic [N_ENG-1:0]   w_pick_onehot;
    logic               w_any_req;
    logic               w_in_range;
    logic               w_write_done;
    logic               w_range_fault;
    logic               w_wrap;
    logic [18:0]        w_pix_next;
    logic               w_done_next;

    assign w_any_req  = |service_req;
    assign w_in_range = (32'(r_x) < FB_W) && (32'(r_y) < FB_H);

    // Rotating-priority search: nearest set request after the last grant, with wrap.
    // Walking the offsets from far to near lets the nearest hit overwrite the others.
    always_comb begin
        w_pick = r_last_grant;
        w_sum  = '0;
        for (int k = N_ENG; k >= 1; k--) begin
            w_sum = {1'b0, r_last_grant} + (GrantW + 1)'(k);
            if (w_sum >= (GrantW + 1)'(N_ENG)) begin
                w_sum = w_sum - (GrantW + 1)'(N_ENG);
            end
            if (service_req[w_sum[GrantW-1:0]]) begin
                w_pick = w_sum[GrantW-1:0];
            end
        end
        w_pick_onehot         = '0;
        w_pick_onehot[w_pick] = 1'b1;
    end

    // State register.
    always_ff @(posedge Engine_CLK or posedge eRST) begin
        if (eRST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and frame-buffer strobe.
    always_comb begin
        w_state_next  = r_state;
        fb_we         = 1'b0;
        w_range_fault = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_next = StAck;
                end
            end
            StAck: begin
                w_state_next = StWrite;
            end
            StWrite: begin
                if (!w_in_range) begin
                    // Bad coordinate: drop the pixel without strobing the frame buffer.
                    w_range_fault = 1'b1;
                    w_state_next  = StRelease;
                end else begin
                    fb_we = 1'b1;
                    if (fb_ready) begin
                        w_state_next = StRelease;
                    end
                end
            end
            StRelease: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Grant selection, registered one-hot acknowledge and last-grant pointer.
    always_ff @(posedge Engine_CLK or posedge eRST) begin
        if (eRST) begin
            r_grant      <= '0;
            r_last_grant <= GrantW'(N_ENG - 1);
            r_ack        <= '0;
        end else begin
            r_ack <= '0;
            if (r_state == StIdle && w_any_req) begin
                r_grant <= w_pick;
                r_ack   <= w_pick_onehot;
            end
            if (r_state == StAck) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Capture the granted engine's result at the end of the acknowledge cycle.
    always_ff @(posedge Engine_CLK or posedge eRST) begin
        if (eRST) begin
            r_x    <= '0;
            r_y    <= '0;
            r_iter <= '0;
        end else if (r_state == StAck) begin
            r_x    <= res_bus[26:17];
            r_y    <= res_bus[16:8];
            r_iter <= res_bus[7:0];
        end
    end

    assign w_write_done = fb_we && fb_ready;
    assign w_wrap       = (32'(r_pix_cnt) + 32'd1) == FrameSz;

    // Pixel counter next value; a write coinciding with frame_start counts as the first pixel.
    always_comb begin
        w_pix_next  = r_pix_cnt;
        w_done_next = 1'b0;
        if (frame_start) begin
            w_pix_next = w_write_done ? 19'd1 : 19'd0;
        end else if (w_write_done) begin
            if (w_wrap) begin
                w_pix_next  = '0;
                w_done_next = 1'b1;
            end else begin
                w_pix_next = r_pix_cnt + 19'd1;
            end
        end
    end

    // Pixel counter, frame-done pulse and sticky range error.
    always_ff @(posedge Engine_CLK or posedge eRST) begin
        if (eRST) begin
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_range_err  <= 1'b0;
        end else begin
            r_pix_cnt    <= w_pix_next;
            r_frame_done <= w_done_next;
            if (w_range_fault) begin
                r_range_err <= 1'b1;
            end else if (frame_start) begin
                r_range_err <= 1'b0;
            end
        end
    end

    assign req_ack    = r_ack;
    assign fb_addr    = 19'(r_y) * 19'(FB_W) + 19'(r_x);
    assign fb_data    = r_iter;
    assign frame_done = r_frame_done;
    assign range_err  = r_range_err;

endmodule
